// File: rtl/fwd_hazard_track.sv
// Forwarding and load-use hazard unit: tracks in-flight destinations through DEPTH post-ID slots.
// Optional macro FWD_STALL_CNT_EN adds a saturating 32-bit stall counter output (stall_cnt_o).
module fwd_hazard_track #(
  parameter int ADDR_W   = 5,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = 3,
  parameter int LOAD_LAT = 1,
  parameter int SEL_W    = $clog2(DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*ADDR_W-1:0] id_rs_addr_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic [ADDR_W-1:0]         id_rd_addr_i,
  input  logic                      id_regwrite_i,
  input  logic                      id_memread_i,
  input  logic                      flush_i,
  input  logic                      hold_i,
  output logic                      stall_o,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
`ifdef FWD_STALL_CNT_EN
  output logic [31:0]               stall_cnt_o,
`endif
  output logic                      ex_valid_o
);

  // Slot 1 = EX ... slot DEPTH = WB; each slot tracks the producer occupying that stage.
  logic              slot_valid    [1:DEPTH];
  logic [ADDR_W-1:0] slot_rd       [1:DEPTH];
  logic              slot_regwrite [1:DEPTH];
  logic              slot_memread  [1:DEPTH];

  logic [NUM_SRC-1:0]       match [1:DEPTH-1];
  logic                     hazard;
  logic [NUM_SRC*SEL_W-1:0] next_sel;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q;

  always_comb begin
    for (int k = 1; k <= DEPTH - 1; k++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        match[k][s] = slot_valid[k] && slot_regwrite[k] &&
                      (slot_rd[k] != '0) && id_rs_used_i[s] &&
                      (slot_rd[k] == id_rs_addr_i[s*ADDR_W +: ADDR_W]);
      end
    end
  end

  // A load is not forwardable while it sits in slots 1..LOAD_LAT.
  always_comb begin
    hazard = 1'b0;
    for (int k = 1; k <= LOAD_LAT; k++) begin
      if ((|match[k]) && slot_memread[k]) hazard = 1'b1;
    end
    hazard = hazard && id_valid_i;
  end

  assign stall_o = hazard && !flush_i;

  // Scan oldest to youngest so the youngest producer overrides.
  always_comb begin
    next_sel = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        if (match[k][s]) next_sel[s*SEL_W +: SEL_W] = SEL_W'(k);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 1; k <= DEPTH; k++) begin
        slot_valid[k]    <= 1'b0;
        slot_rd[k]       <= '0;
        slot_regwrite[k] <= 1'b0;
        slot_memread[k]  <= 1'b0;
      end
      fwd_sel_q <= '0;
    end else if (!hold_i) begin
      for (int k = DEPTH; k >= 2; k--) begin
        slot_valid[k]    <= slot_valid[k-1];
        slot_rd[k]       <= slot_rd[k-1];
        slot_regwrite[k] <= slot_regwrite[k-1];
        slot_memread[k]  <= slot_memread[k-1];
      end
      slot_valid[1]    <= id_valid_i && !stall_o && !flush_i;
      slot_rd[1]       <= id_rd_addr_i;
      slot_regwrite[1] <= id_regwrite_i;
      slot_memread[1]  <= id_memread_i;
      fwd_sel_q        <= next_sel;
    end
  end

  assign fwd_sel_o  = fwd_sel_q;
  assign ex_valid_o = slot_valid[1];

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && !hold_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_track.sv
// Directed bench for fwd_hazard_track (default parameters) with hand-computed expectations.
module tb_fwd_hazard_track;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       id_valid_i;
  logic [9:0] id_rs_addr_i;
  logic [1:0] id_rs_used_i;
  logic [4:0] id_rd_addr_i;
  logic       id_regwrite_i;
  logic       id_memread_i;
  logic       flush_i;
  logic       hold_i;
  logic       stall_o;
  logic [3:0] fwd_sel_o;
  logic       ex_valid_o;
`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  fwd_hazard_track dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rs_used_i(id_rs_used_i),
    .id_rd_addr_i(id_rd_addr_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .flush_i(flush_i), .hold_i(hold_i),
    .stall_o(stall_o), .fwd_sel_o(fwd_sel_o),
`ifdef FWD_STALL_CNT_EN
    .stall_cnt_o(stall_cnt_o),
`endif
    .ex_valid_o(ex_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs0, input logic [4:0] rs1,
                       input logic [1:0] used, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic fl, input logic hd);
    id_valid_i    = v;
    id_rs_addr_i  = {rs1, rs0};
    id_rs_used_i  = used;
    id_rd_addr_i  = rd;
    id_regwrite_i = rw;
    id_memread_i  = mr;
    flush_i       = fl;
    hold_i        = hd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic exv, input logic [1:0] s0,
                            input logic [1:0] s1);
    check({tag, "_exv"}, 32'(ex_valid_o), 32'(exv));
    check({tag, "_sel0"}, 32'(fwd_sel_o[1:0]), 32'(s0));
    check({tag, "_sel1"}, 32'(fwd_sel_o[3:2]), 32'(s1));
  endtask

  initial begin
    rst_i = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    check("rst_stall", 32'(stall_o), 0);
    check_regs("rst", 0, 0, 0);
    #1 rst_i = 1'b1;

    // Back-to-back dependency: add x5 then reader of x5 -> select 1
    drive(1, 0, 0, 2'b00, 5, 1, 0, 0, 0);
    check("add5_stall", 32'(stall_o), 0);
    tick();
    check_regs("add5", 1, 0, 0);
    drive(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
    check("use5_stall", 32'(stall_o), 0);
    tick();
    check_regs("use5", 1, 1, 0);

    // One-gap dependency on operand 1 -> select 2, then x5 in WB -> 0
    drive(1, 0, 0, 2'b00, 5, 1, 0, 0, 0);
    tick();
    drive(1, 1, 2, 2'b11, 10, 1, 0, 0, 0);
    tick();
    check_regs("unrel", 1, 0, 0);
    drive(1, 3, 5, 2'b10, 0, 0, 0, 0, 0);
    tick();
    check_regs("gap1", 1, 0, 2);
    drive(1, 10, 5, 2'b11, 0, 0, 0, 0, 0);
    tick();
    check_regs("gap2", 1, 2, 0);

    // Load-use: one stall cycle, bubble, then select 2
    drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);
    check("lw7_stall", 32'(stall_o), 0);
    tick();
    drive(1, 7, 0, 2'b01, 0, 0, 0, 0, 0);
    check("lu_stall", 32'(stall_o), 1);
    tick();
    check_regs("lu_bub", 0, 1, 0);
`ifdef FWD_STALL_CNT_EN
    check("lu_cnt", stall_cnt_o, 1);
`endif
    check("lu_retry_stall", 32'(stall_o), 0);
    tick();
    check_regs("lu_retry", 1, 2, 0);

    // Load-use with flush in the would-be stall cycle: no stall, bubble
    drive(1, 0, 0, 2'b00, 7, 1, 1, 0, 0);
    tick();
    drive(1, 7, 0, 2'b01, 0, 0, 0, 1, 0);
    check("fl_stall", 32'(stall_o), 0);
    tick();
    check("fl_exv", 32'(ex_valid_o), 0);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    tick();
    check_regs("fl_idle", 0, 0, 0);

    // Load writing x0 is never forwarded and never stalls
    drive(1, 0, 0, 2'b00, 0, 1, 1, 0, 0);
    tick();
    drive(1, 0, 0, 2'b11, 0, 0, 0, 0, 0);
    check("x0_stall", 32'(stall_o), 0);
    tick();
    check_regs("x0", 1, 0, 0);

    // Two writers of x9: youngest wins
    drive(1, 0, 0, 2'b00, 9, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 2'b00, 9, 1, 0, 0, 0);
    tick();
    drive(1, 9, 9, 2'b11, 0, 0, 0, 0, 0);
    tick();
    check_regs("x9", 1, 1, 1);

    // Load x11 (also reads x9 from slot 2), then freeze with a dependent reader in ID
    drive(1, 9, 9, 2'b11, 11, 1, 1, 0, 0);
    tick();
    check_regs("lw11", 1, 2, 2);
    drive(1, 11, 0, 2'b01, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      check("hold_stall", 32'(stall_o), 1);
      tick();
      check_regs("hold", 1, 2, 2);
    end
    drive(1, 11, 0, 2'b01, 0, 0, 0, 0, 0);
    check("unhold_stall", 32'(stall_o), 1);
    tick();
    check_regs("unhold", 0, 1, 0);
    tick();
    check_regs("unhold_retry", 1, 2, 0);
`ifdef FWD_STALL_CNT_EN
    check("cnt_end", stall_cnt_o, 2);
`endif

    // Asynchronous reset mid-stream with a stall pending
    drive(1, 0, 0, 2'b00, 12, 1, 1, 0, 0);
    tick();
    drive(1, 12, 0, 2'b01, 0, 0, 0, 0, 0);
    check("pre_rst_stall", 32'(stall_o), 1);
    rst_i = 1'b0;
    #1;
    check("mid_rst_stall", 32'(stall_o), 0);
    check_regs("mid_rst", 0, 0, 0);
`ifdef FWD_STALL_CNT_EN
    check("mid_rst_cnt", stall_cnt_o, 0);
`endif
    rst_i = 1'b1;
    #1;
    check("post_rst_stall", 32'(stall_o), 0);
    tick();
    check_regs("post_rst", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_track.md
Name: fwd_hazard_track

Overview:
- Parametrised forwarding and hazard unit for the in-order RISC-V pipeline; successor to the stateless forwarding selector.
- Internally tracks in-flight destination registers through DEPTH post-ID slots (slot 1 = EX, slot 2 = MEM, ... slot DEPTH = WB) and issues registered per-operand forward selects for the EX stage.
- Also generates the load-use stall, parametrised by load latency.
- Sits beside the ID/EX pipeline register; drives the EX operand muxes and the PC/IF_ID hold.

Parameters:
- ADDR_W, 5, register address width
- NUM_SRC, 2, number of source operands per instruction
- DEPTH, 3, tracked slots after ID (EX..WB); legal range 2..8
- LOAD_LAT, 1, number of slots (starting at slot 1) in which a load result is not yet forwardable; 1 <= LOAD_LAT < DEPTH
- SEL_W, $clog2(DEPTH), forward-select width per operand

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- id_valid_i  in  1  ID holds a real instruction
- id_rs_addr_i  in  NUM_SRC*ADDR_W  source addresses; operand s at bits [s*ADDR_W +: ADDR_W]
- id_rs_used_i  in  NUM_SRC  operand s actually read
- id_rd_addr_i  in  ADDR_W  destination address
- id_regwrite_i  in  1  instruction writes rd
- id_memread_i  in  1  instruction is a load
- flush_i  in  1  kill the ID instruction (taken branch); inserts a bubble
- hold_i  in  1  global pipeline freeze (memory back-pressure)
- stall_o  out  1  load-use stall; combinational
- fwd_sel_o  out  NUM_SRC*SEL_W  registered EX-stage forward selects
- ex_valid_o  out  1  slot 1 occupied by a real instruction

Behaviour:
- Slot k holds {valid, rd, regwrite, memread}. "Match(k, s)" = slot[k].valid & slot[k].regwrite & slot[k].rd != 0 & id_rs_used_i[s] & slot[k].rd == rs[s].
- Hazard: id_valid_i & exists s, k in 1..LOAD_LAT with Match(k, s) & slot[k].memread.
- stall_o = hazard & !flush_i; a flushed instruction never stalls.
- Advance occurs on a rising edge when hold_i = 0:
  - slot[k+1] <= slot[k] for k = 1..DEPTH-1; slot[DEPTH] retires.
  - slot[1] <= ID info if id_valid_i & !stall_o & !flush_i; otherwise a bubble (valid = 0).
  - fwd_sel_o[s] <= smallest k in 1..DEPTH-1 with Match(k, s), else 0.
- Select encoding:
  - 0 = register file.
  - k = result of the stage one past slot k next cycle (1 = MEM, 2 = WB, ...).
  - The youngest producer wins.
  - Slot DEPTH is not a forward source; the register file is write-through for that retirement.
- When a stall is asserted, fwd_sel_o is still updated, but slot 1 is a bubble, so EX ignores it.
- hold_i = 1: all slots, fwd_sel_o and ex_valid_o hold. stall_o is still computed from the held state.
- The rd = 0 check means x0 is never forwarded and never stalls.
- Latency: one cycle from ID compare to fwd_sel_o. stall_o has zero latency.
- Reset (rst_i = 0, asynchronous):
  - all slots invalid; fwd_sel_o = 0; ex_valid_o = 0.
  - stall_o therefore 0.
  - Reset mid-operation discards all in-flight tracking; the first instruction after release sees no producers.
- A producer in slot 1 that is a load with LOAD_LAT = 1 stalls exactly one cycle. On the next edge it moves to slot 2, and the retried ID instruction gets select 2.

Optional Feature:
- Macro FWD_STALL_CNT_EN.
- Defined: adds port stall_cnt_o (out, 32). It increments on every edge where stall_o = 1 and hold_i = 0, saturates at 0xFFFFFFFF, and resets to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Defaults. Cycle n: ID "add x5" (regwrite). Cycle n+1: ID uses rs1 = x5 -> fwd_sel_o[0] = 1 at n+2, stall_o = 0.
- "add x5", then an unrelated instruction, then a user of rs2 = x5 -> fwd_sel_o[1] = 2; a further gap gives 0.
- "lw x7", then a user of rs1 = x7 -> stall_o = 1 for exactly one cycle, slot 1 bubble (ex_valid_o = 0), then fwd_sel_o[0] = 2. With FWD_STALL_CNT_EN, stall_cnt_o = 1.
- Same load-use pair with flush_i = 1 during the would-be stall cycle -> stall_o = 0, bubble inserted, no forward.
- Writer to x0, then a user of x0 -> fwd_sel_o = 0, no stall. Two writers of x9 back-to-back -> the reader gets select 1, not 2.
- hold_i = 1 for 3 cycles mid-sequence -> outputs frozen, selects resume unchanged. Assert rst_i = 0 mid-stream -> all outputs 0 immediately without a clock edge.
